// File: rtl/mp_icache_dm_if.sv
// Fetch-side and refill-side bus bundle for the direct-mapped instruction cache.
// The cache uses the slave modport; the fetch stage / backing memory model uses master.
interface mp_icache_dm_if #(
    parameter int ADDR_W = 30
) ();
    logic              icache_ack;
    logic [ADDR_W-1:0] icache_addr;
    logic              icache_flush;
    logic              icache_vld;
    logic [31:0]       icache_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_gnt;
    logic              mem_rvld;
    logic [31:0]       mem_rdata;

    modport slave (
        input  icache_ack, icache_addr, icache_flush, mem_gnt, mem_rvld, mem_rdata,
        output icache_vld, icache_data, mem_req, mem_addr
    );

    modport master (
        output icache_ack, icache_addr, icache_flush, mem_gnt, mem_rvld, mem_rdata,
        input  icache_vld, icache_data, mem_req, mem_addr
    );
endinterface

// File: rtl/mp_icache_dm.sv
// Direct-mapped instruction cache with full-line burst refill and optional byte-swapped output.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STAT_EN.
module mp_icache_dm #(
    parameter int ADDR_W     = 30,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 64,
    parameter int BYTE_SWAP  = 1
) (
    input logic            sysclk,
    input logic            sys_rst,
    mp_icache_dm_if.slave  bus
`ifdef ICACHE_STAT_EN
    ,
    output logic [31:0]    stat_hit,
    output logic [31:0]    stat_miss
`endif
);
    localparam int OB = $clog2(LINE_WORDS);
    localparam int IB = $clog2(SETS);
    localparam int TW = ADDR_W - OB - IB;

    typedef enum logic [1:0] {IDLE, REQ, REFILL, RESP} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] req_q;
    logic [OB-1:0]     beat_q;
    logic [31:0]       cap_q;
    logic              flush_pend_q;
    logic [SETS-1:0]   valid_q;
    logic              vld_q;
    logic [31:0]       data_q;

    logic [31:0]       data_ram [SETS*LINE_WORDS];
    logic [TW-1:0]     tag_ram  [SETS];

    logic [OB-1:0]     a_off, r_off;
    logic [IB-1:0]     a_idx, r_idx;
    logic [TW-1:0]     a_tag, r_tag;
    logic              serving, accept, hit, beat, last_beat;
    logic [31:0]       resp_word;

    function automatic logic [31:0] fetch_word(input logic [31:0] w);
        if (BYTE_SWAP != 0)
            return {w[7:0], w[15:8], w[23:16], w[31:24]};
        return w;
    endfunction

    assign a_off = bus.icache_addr[OB-1:0];
    assign a_idx = bus.icache_addr[OB+IB-1:OB];
    assign a_tag = bus.icache_addr[ADDR_W-1:OB+IB];
    assign r_off = req_q[OB-1:0];
    assign r_idx = req_q[OB+IB-1:OB];
    assign r_tag = req_q[ADDR_W-1:OB+IB];

    // RESP behaves like IDLE for new fetches, so a fetch issued on the
    // response cycle is not lost.
    assign serving   = (state_q == IDLE) || (state_q == RESP);
    assign accept    = serving && bus.icache_ack;
    assign hit       = valid_q[a_idx] && (tag_ram[a_idx] == a_tag);
    assign beat      = (state_q == REFILL) && bus.mem_rvld;
    assign last_beat = beat && (beat_q == OB'(LINE_WORDS - 1));
    assign resp_word = (beat_q == r_off) ? bus.mem_rdata : cap_q;

    assign bus.mem_req     = (state_q == REQ);
    assign bus.mem_addr    = {req_q[ADDR_W-1:OB], {OB{1'b0}}};
    assign bus.icache_vld  = vld_q;
    assign bus.icache_data = data_q;

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) state_q <= IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, RESP: state_d = (accept && !hit) ? REQ : IDLE;
            REQ:        if (bus.mem_gnt) state_d = REFILL;
            REFILL:     if (last_beat)   state_d = RESP;
            default:    state_d = IDLE;
        endcase
    end

    // Storage arrays carry no reset; validity lives in valid_q.
    always_ff @(posedge sysclk) begin
        if (beat) begin
            data_ram[{r_idx, beat_q}] <= bus.mem_rdata;
            if (beat_q == r_off) cap_q <= bus.mem_rdata;
        end
        if (last_beat) tag_ram[r_idx] <= r_tag;
    end

    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            req_q        <= '0;
            beat_q       <= '0;
            flush_pend_q <= 1'b0;
            valid_q      <= '0;
            vld_q        <= 1'b1;
            data_q       <= 32'h0;
        end else begin
            if (accept) begin
                req_q <= bus.icache_addr;
                if (hit) begin
                    data_q <= fetch_word(data_ram[{a_idx, a_off}]);
                    vld_q  <= 1'b1;
                end else begin
                    vld_q  <= 1'b0;
                end
            end
            if (beat) beat_q <= beat_q + 1'b1;
            if ((state_q == REQ || state_q == REFILL) && bus.icache_flush)
                flush_pend_q <= 1'b1;
            // A flush seen during the miss drops the new line and every other one.
            if (last_beat) begin
                data_q       <= fetch_word(resp_word);
                vld_q        <= 1'b1;
                flush_pend_q <= 1'b0;
                if (flush_pend_q || bus.icache_flush) valid_q <= '0;
                else                                  valid_q[r_idx] <= 1'b1;
            end
            if (serving && bus.icache_flush) valid_q <= '0;
        end
    end

`ifdef ICACHE_STAT_EN
    always_ff @(posedge sysclk or posedge sys_rst) begin
        if (sys_rst) begin
            stat_hit  <= 32'h0;
            stat_miss <= 32'h0;
        end else if (accept) begin
            if (hit && stat_hit != 32'hFFFF_FFFF)
                stat_hit <= stat_hit + 32'd1;
            if (!hit && stat_miss != 32'hFFFF_FFFF)
                stat_miss <= stat_miss + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_mp_icache_dm.sv
// Scoreboard bench for mp_icache_dm: expected words queued at each fetch, popped when served.
module tb_mp_icache_dm;
    localparam int ADDR_W = 30;
    localparam int LW     = 4;
    localparam int SETS   = 64;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mp_icache_dm_if #(.ADDR_W(ADDR_W)) bus ();
`ifdef ICACHE_STAT_EN
    logic [31:0] stat_hit, stat_miss;
`endif

    mp_icache_dm #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .SETS(SETS), .BYTE_SWAP(1)) dut (
        .sysclk (clk),
        .sys_rst(rst),
        .bus    (bus)
`ifdef ICACHE_STAT_EN
        ,
        .stat_hit (stat_hit),
        .stat_miss(stat_miss)
`endif
    );

    int          n_run  = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_w;

    bit          req_seen, addr_stable, vld_low;
    logic        req_after_gnt;
    logic [29:0] req_addr;

    function automatic logic [31:0] mw(input logic [29:0] a);
        return {a[7:0] ^ 8'h3C, a[15:8] + 8'h11, a[7:0], 8'hE7};
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic issue(input logic [29:0] a, input logic fl);
        bus.icache_ack   = 1'b1;
        bus.icache_addr  = a;
        bus.icache_flush = fl;
        exp_q.push_back(bswap(mw(a)));
        @(negedge clk);
        bus.icache_ack   = 1'b0;
        bus.icache_flush = 1'b0;
    endtask

    task automatic pop_exp();
        if (exp_q.size() == 0) exp_w = 32'hDEAD_BEEF;
        else                   exp_w = exp_q.pop_front();
    endtask

    // Backing-memory model: waits for the request, grants after gdly cycles,
    // then sends LW beats with gap idle cycles before each.
    task automatic refill(input int gdly, input int gap, input int flush_beat, input int rst_beat);
        logic [29:0] base;
        req_seen = 0; addr_stable = 1; vld_low = 1; req_after_gnt = 1'bx;
        for (int n = 0; n < 20 && bus.mem_req !== 1'b1; n++) @(negedge clk);
        if (bus.mem_req !== 1'b1) return;
        req_seen = 1;
        req_addr = bus.mem_addr;
        base     = bus.mem_addr;
        for (int n = 0; n < gdly; n++) begin
            if (bus.mem_req !== 1'b1 || bus.mem_addr !== base) addr_stable = 0;
            if (bus.icache_vld !== 1'b0) vld_low = 0;
            @(negedge clk);
        end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        req_after_gnt = bus.mem_req;
        for (int i = 0; i < LW; i++) begin
            for (int g = 0; g < gap; g++) begin
                if (bus.icache_vld !== 1'b0) vld_low = 0;
                @(negedge clk);
            end
            if (bus.icache_vld !== 1'b0) vld_low = 0;
            bus.mem_rvld     = 1'b1;
            bus.mem_rdata    = mw(base + 30'(i));
            bus.icache_flush = (i == flush_beat);
            if (i == rst_beat) rst = 1'b1;
            @(negedge clk);
            bus.mem_rvld     = 1'b0;
            bus.icache_flush = 1'b0;
            if (i == rst_beat) begin
                rst = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_run++; if (bus.icache_vld !== 1'b1)   begin n_fail++; $display("FAIL reset_vld got %b want 1", bus.icache_vld); end
        n_run++; if (bus.icache_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h want 0", bus.icache_data); end
        n_run++; if (bus.mem_req !== 1'b0)      begin n_fail++; $display("FAIL reset_req got %b want 0", bus.mem_req); end
        n_run++; if (bus.mem_addr !== 30'h0)    begin n_fail++; $display("FAIL reset_maddr got %h want 0", bus.mem_addr); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cold_miss();
        issue(30'h10, 1'b0);
        n_run++; if (bus.icache_vld !== 1'b0) begin n_fail++; $display("FAIL cold_stall got %b want 0", bus.icache_vld); end
        refill(0, 0, -1, -1);
        n_run++; if (!req_seen || req_addr !== 30'h10) begin n_fail++; $display("FAIL cold_maddr got %h seen %0d want 10", req_addr, req_seen); end
        n_run++; if (req_after_gnt !== 1'b0) begin n_fail++; $display("FAIL cold_req_drop got %b want 0", req_after_gnt); end
        n_run++; if (!vld_low) begin n_fail++; $display("FAIL cold_vld_low got 0 want 1"); end
        pop_exp();
        n_run++; if (bus.icache_vld !== 1'b1 || bus.icache_data !== exp_w)
            begin n_fail++; $display("FAIL cold_data got %b/%h want 1/%h", bus.icache_vld, bus.icache_data, exp_w); end
    endtask

    task automatic test_hit();
`ifdef ICACHE_STAT_EN
        logic [31:0] h0;
        h0 = stat_hit;
`endif
        issue(30'h12, 1'b0);
        pop_exp();
        n_run++; if (bus.icache_vld !== 1'b1 || bus.icache_data !== exp_w)
            begin n_fail++; $display("FAIL hit_data got %b/%h want 1/%h", bus.icache_vld, bus.icache_data, exp_w); end
        @(negedge clk);
        n_run++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL hit_no_req got %b want 0", bus.mem_req); end
`ifdef ICACHE_STAT_EN
        n_run++; if (stat_hit !== h0 + 32'd1) begin n_fail++; $display("FAIL stat_hit got %0d want %0d", stat_hit, h0 + 32'd1); end
`endif
    endtask

    task automatic test_conflict();
`ifdef ICACHE_STAT_EN
        logic [31:0] m0;
`endif
        issue(30'h10 + 30'(SETS * 4), 1'b0);
        n_run++; if (bus.icache_vld !== 1'b0) begin n_fail++; $display("FAIL conf_stall got %b want 0", bus.icache_vld); end
        refill(0, 0, -1, -1);
        pop_exp();
        n_run++; if (bus.icache_vld !== 1'b1 || bus.icache_data !== exp_w)
            begin n_fail++; $display("FAIL conf_data got %b/%h want 1/%h", bus.icache_vld, bus.icache_data, exp_w); end
`ifdef ICACHE_STAT_EN
        m0 = stat_miss;
`endif
        issue(30'h10, 1'b0);
        n_run++; if (bus.icache_vld !== 1'b0) begin n_fail++; $display("FAIL conf_remiss got %b want 0", bus.icache_vld); end
`ifdef ICACHE_STAT_EN
        n_run++; if (stat_miss !== m0 + 32'd1) begin n_fail++; $display("FAIL stat_miss got %0d want %0d", stat_miss, m0 + 32'd1); end
`endif
        refill(0, 0, -1, -1);
        pop_exp();
        n_run++; if (bus.icache_data !== exp_w) begin n_fail++; $display("FAIL conf_redata got %h want %h", bus.icache_data, exp_w); end
    endtask

    task automatic test_flush_refill();
        issue(30'h31, 1'b0);
        refill(0, 0, 2, -1);
        pop_exp();
        n_run++; if (bus.icache_vld !== 1'b1 || bus.icache_data !== exp_w)
            begin n_fail++; $display("FAIL flref_data got %b/%h want 1/%h", bus.icache_vld, bus.icache_data, exp_w); end
        @(negedge clk);
        issue(30'h31, 1'b0);
        n_run++; if (bus.icache_vld !== 1'b0) begin n_fail++; $display("FAIL flref_remiss got %b want 0", bus.icache_vld); end
        refill(0, 0, -1, -1);
        pop_exp();
        @(negedge clk);
        issue(30'h13, 1'b0);
        n_run++; if (bus.icache_vld !== 1'b0) begin n_fail++; $display("FAIL flref_other_inval got %b want 0", bus.icache_vld); end
        refill(0, 0, -1, -1);
        pop_exp();
        n_run++; if (bus.icache_data !== exp_w) begin n_fail++; $display("FAIL flref_other_data got %h want %h", bus.icache_data, exp_w); end
    endtask

    task automatic test_gapped();
        issue(30'h47, 1'b0);
        refill(5, 3, -1, -1);
        n_run++; if (req_addr !== 30'h44) begin n_fail++; $display("FAIL gap_maddr got %h want 44", req_addr); end
        n_run++; if (!addr_stable) begin n_fail++; $display("FAIL gap_stable got 0 want 1"); end
        n_run++; if (!vld_low) begin n_fail++; $display("FAIL gap_vld_low got 0 want 1"); end
        pop_exp();
        n_run++; if (bus.icache_vld !== 1'b1 || bus.icache_data !== exp_w)
            begin n_fail++; $display("FAIL gap_data got %b/%h want 1/%h", bus.icache_vld, bus.icache_data, exp_w); end
    endtask

    task automatic test_reset_refill();
        issue(30'h58, 1'b0);
        refill(0, 0, -1, 1);
        pop_exp();
        n_run++; if (bus.icache_vld !== 1'b1 || bus.icache_data !== 32'h0 || bus.mem_req !== 1'b0)
            begin n_fail++; $display("FAIL rstref_state got %b/%h/%b want 1/0/0", bus.icache_vld, bus.icache_data, bus.mem_req); end
        for (int i = 0; i < 3; i++) begin
            bus.mem_rvld = 1'b1; bus.mem_rdata = 32'hBAD0_0000 + 32'(i);
            @(negedge clk);
        end
        bus.mem_rvld = 1'b0;
        n_run++; if (bus.icache_vld !== 1'b1 || bus.icache_data !== 32'h0 || bus.mem_req !== 1'b0)
            begin n_fail++; $display("FAIL rstref_stray got %b/%h/%b want 1/0/0", bus.icache_vld, bus.icache_data, bus.mem_req); end
        issue(30'h58, 1'b0);
        n_run++; if (bus.icache_vld !== 1'b0) begin n_fail++; $display("FAIL rstref_remiss got %b want 0", bus.icache_vld); end
        refill(0, 0, -1, -1);
        pop_exp();
        n_run++; if (bus.icache_data !== exp_w) begin n_fail++; $display("FAIL rstref_data got %h want %h", bus.icache_data, exp_w); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] last;
        @(negedge clk);
        for (int i = 0; i < LW; i++) begin
            bus.icache_ack  = 1'b1;
            bus.icache_addr = 30'h58 + 30'(i);
            exp_q.push_back(bswap(mw(30'h58 + 30'(i))));
            @(negedge clk);
            pop_exp();
            n_run++; if (bus.icache_vld !== 1'b1 || bus.icache_data !== exp_w)
                begin n_fail++; $display("FAIL b2b_%0d got %b/%h want 1/%h", i, bus.icache_vld, bus.icache_data, exp_w); end
        end
        bus.icache_ack  = 1'b0;
        bus.icache_addr = 30'h0;
        last = bswap(mw(30'h5B));
        repeat (2) @(negedge clk);
        n_run++; if (bus.icache_data !== last || bus.icache_vld !== 1'b1)
            begin n_fail++; $display("FAIL b2b_hold got %b/%h want 1/%h", bus.icache_vld, bus.icache_data, last); end
    endtask

    task automatic test_flush_idle();
        issue(30'h5A, 1'b1);
        pop_exp();
        n_run++; if (bus.icache_vld !== 1'b1 || bus.icache_data !== exp_w)
            begin n_fail++; $display("FAIL flidle_prehit got %b/%h want 1/%h", bus.icache_vld, bus.icache_data, exp_w); end
        issue(30'h5B, 1'b0);
        n_run++; if (bus.icache_vld !== 1'b0) begin n_fail++; $display("FAIL flidle_miss got %b want 0", bus.icache_vld); end
        refill(2, 1, -1, -1);
        pop_exp();
        n_run++; if (bus.icache_data !== exp_w) begin n_fail++; $display("FAIL flidle_data got %h want %h", bus.icache_data, exp_w); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.icache_ack   = 1'b0;
        bus.icache_addr  = '0;
        bus.icache_flush = 1'b0;
        bus.mem_gnt      = 1'b0;
        bus.mem_rvld     = 1'b0;
        bus.mem_rdata    = 32'h0;
        test_reset();
        test_cold_miss();
        test_hit();
        test_conflict();
        test_flush_refill();
        test_gapped();
        test_reset_refill();
        test_back_to_back();
        test_flush_idle();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
